// File: rtl/mips_pkg.sv
// Shared MIPS definitions.
//   - imem_ld_state_t : state encoding of the instruction-memory boot loader
//   - IMEM_DEPTH      : instruction memory depth in words
//   - opcode / funct codes used by the core, plus small encoders for building
//     instruction words.
package mips_pkg;

    localparam int IMEM_DEPTH = 256;

    typedef enum logic [2:0] {
        ST_HDR_HI = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERR    = 3'd5
    } imem_ld_state_t;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes
    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_JR  = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2a;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

endpackage

// File: rtl/sram_sp_rbw.sv
// Single-port synchronous RAM, registered read, read-before-write.
//   clk   : clock
//   rst   : sync active-high; clears only the read register, never the array
//   we    : write enable for addr this cycle
//   addr  : shared read/write word address
//   wdata : write data
//   rdata : mem[addr] as it was before this edge's write, 1-cycle latency
module sram_sp_rbw #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_p1;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read stage: the array read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1 <= '0;
        end else begin
            rdata_p1 <= mem[addr];
        end
    end

    assign rdata = rdata_p1;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader and fetch port.
// Byte stream framing: count[15:8], count[7:0], count big-endian 32-bit words,
// then an XOR checksum over the data bytes. The core is held in reset until a
// load with a matching checksum completes.
//   clk, rst   : clock, sync active-high reset
//   s_valid    : loader byte valid
//   s_ready    : loader byte ready (independent of s_valid)
//   s_data     : loader byte
//   core_addr  : core fetch word address
//   core_rdata : fetched word, 1-cycle registered latency
//   core_rst   : reset to the core, low only in RUN
//   load_done  : high in RUN
//   err        : high in ERR
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic [ADDR_W-1:0] core_addr,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              err
);

    localparam logic [16:0] MAX_COUNT = 17'(2 ** ADDR_W);

    imem_ld_state_t state, state_nxt;

    logic [7:0]        count_hi;
    logic [15:0]       count;
    logic [ADDR_W:0]   wr_addr;      // one extra bit so count = depth needs no wrap
    logic [1:0]        byte_idx;
    logic [7:0]        csum;
    logic [DATA_W-9:0] asm_q;

    logic              accept;
    logic [15:0]       hdr_count;
    logic              hdr_bad;
    logic              word_last;
    logic              mem_we;
    logic [ADDR_W-1:0] ram_addr;

    assign s_ready   = ~rst & (state inside {ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CSUM});
    assign accept    = s_valid & s_ready;
    assign hdr_count = {count_hi, s_data};
    assign hdr_bad   = (hdr_count == 16'd0) || ({1'b0, hdr_count} > MAX_COUNT);
    assign word_last = (16'(wr_addr) == (count - 16'd1));

    assign load_done = (state == ST_RUN);
    assign err       = (state == ST_ERR);
    assign core_rst  = ~load_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HDR_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                ST_HDR_HI: state_nxt = ST_HDR_LO;
                ST_HDR_LO: state_nxt = hdr_bad ? ST_ERR : ST_DATA;
                ST_DATA: begin
                    if ((byte_idx == 2'd3) && word_last) begin
                        state_nxt = ST_CSUM;
                    end
                end
                ST_CSUM:   state_nxt = (s_data == csum) ? ST_RUN : ST_ERR;
                default:   state_nxt = state;
            endcase
        end
    end

    // Write-address and byte-lane counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr  <= '0;
            byte_idx <= '0;
        end else if (accept) begin
            case (state)
                ST_HDR_LO: begin
                    wr_addr  <= '0;
                    byte_idx <= '0;
                end
                ST_DATA: begin
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Header, checksum and word assembly; reloaded on every frame, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            case (state)
                ST_HDR_HI: count_hi <= s_data;
                ST_HDR_LO: begin
                    count <= hdr_count;
                    csum  <= 8'h00;
                end
                ST_DATA: begin
                    csum  <= csum ^ s_data;
                    asm_q <= {asm_q[DATA_W-17:0], s_data};
                end
                default: ;
            endcase
        end
    end

    // The write borrows the single RAM port; the fetch read that cycle returns
    // the pre-write contents of the written address.
    assign mem_we   = accept && (state == ST_DATA) && (byte_idx == 2'd3);
    assign ram_addr = mem_we ? wr_addr[ADDR_W-1:0] : core_addr;

    sram_sp_rbw #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_imem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .addr  (ram_addr),
        .wdata ({asm_q, s_data}),
        .rdata (core_rdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
    import mips_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [7:0]        s_data = 8'h00;
    logic [ADDR_W-1:0] core_addr = '0;
    logic [DATA_W-1:0] core_rdata;
    logic              core_rst;
    logic              load_done;
    logic              err;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .core_addr  (core_addr),
        .core_rdata (core_rdata),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .err        (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: what the instruction memory must hold, and which words are known.
    logic [31:0] ref_mem [DEPTH];
    bit          ref_known [DEPTH];
    logic [31:0] prog [DEPTH];
    logic [7:0]  byte_q [$];
    bit          gaps = 1'b0;
    bit          exp_run, exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame a stream: header, nwords words from prog (MSB first), XOR checksum.
    task automatic build_stream(input logic [15:0] cnt, input int nwords, input bit corrupt);
        logic [7:0] x;
        logic [31:0] w;
        byte_q.delete();
        byte_q.push_back(cnt[15:8]);
        byte_q.push_back(cnt[7:0]);
        x = 8'h00;
        for (int i = 0; i < nwords; i++) begin
            w = prog[i];
            for (int b = 3; b >= 0; b--) begin
                byte_q.push_back(w[b*8 +: 8]);
                x = x ^ w[b*8 +: 8];
            end
        end
        if (nwords > 0) byte_q.push_back(corrupt ? (x ^ 8'h5a) : x);
    endtask

    // Expected outcome of a complete frame, from the framing rules.
    task automatic model_load(input logic [15:0] cnt, input bit corrupt);
        exp_run = 1'b0;
        exp_err = 1'b0;
        if (cnt == 0 || int'(cnt) > DEPTH) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < int'(cnt); i++) begin
                ref_mem[i]   = prog[i];
                ref_known[i] = 1'b1;
            end
            exp_run = !corrupt;
            exp_err = corrupt;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", core_rdata, 32'd0);
        rst = 1'b0;
        #1;
        check("s_ready_after_rst", 32'(s_ready), 32'd1);
    endtask

    // Send byte_q[first..last]; random idle gaps carry garbage data.
    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                end
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = byte_q[i];
            check("s_ready_load", 32'(s_ready), 32'd1);
            check("core_rst_load", 32'(core_rst), 32'd1);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic check_outcome(input string tag);
        check({tag, "_load_done"}, 32'(load_done), 32'(exp_run));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_core_rst"}, 32'(core_rst), 32'(!exp_run));
        check({tag, "_s_ready"}, 32'(s_ready), 32'(!(exp_run || exp_err)));
    endtask

    task automatic check_mem(input int n);
        for (int a = 0; a < n; a++) begin
            if (ref_known[a]) begin
                @(negedge clk);
                core_addr = 8'(a);
                @(negedge clk);
                check($sformatf("mem[%0d]", a), core_rdata, ref_mem[a]);
            end
        end
    endtask

    task automatic set_nominal();
        prog[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
        prog[1] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, FUNCT_SLL);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old0, new0;
        logic [15:0] cnt;
        bit          corrupt;
        int          nw;

        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

        // Nominal load
        do_reset();
        set_nominal();
        build_stream(16'd2, 2, 1'b0);
        model_load(16'd2, 1'b0);
        send_range(0, byte_q.size() - 1);
        check_outcome("nominal");
        check_mem(2);
        // fetch latency: a new address is not visible before the next edge
        @(negedge clk);
        core_addr = 8'd0;
        @(negedge clk);
        core_addr = 8'd1;
        #1;
        check("latency_hold", core_rdata, 32'h2001_0005);
        @(negedge clk);
        check("latency_new", core_rdata, 32'h0000_0000);

        // Bytes offered in RUN are ignored
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'hff;
        check("run_s_ready", 32'(s_ready), 32'd0);
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
        check("run_stays", 32'(load_done), 32'd1);
        check_mem(2);

        // Bad checksum
        do_reset();
        set_nominal();
        build_stream(16'd2, 2, 1'b0);
        byte_q[byte_q.size() - 1] = 8'h25;
        model_load(16'd2, 1'b1);
        send_range(0, byte_q.size() - 1);
        check_outcome("bad_csum");
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);

        // Header bounds: 0 and 257
        do_reset();
        build_stream(16'd0, 0, 1'b0);
        model_load(16'd0, 1'b0);
        send_range(0, 1);
        check_outcome("hdr_zero");
        do_reset();
        build_stream(16'd257, 0, 1'b0);
        model_load(16'd257, 1'b0);
        send_range(0, 1);
        check_outcome("hdr_257");
        do_reset();
        cnt = 16'($urandom_range(258, 65535));
        build_stream(cnt, 0, 1'b0);
        model_load(cnt, 1'b0);
        send_range(0, 1);
        check_outcome("hdr_big");

        // Full depth: 256 words
        do_reset();
        for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
        build_stream(16'd256, 256, 1'b0);
        model_load(16'd256, 1'b0);
        send_range(0, byte_q.size() - 1);
        check_outcome("full256");
        check_mem(DEPTH);

        // Nominal stream with random gaps
        gaps = 1'b1;
        do_reset();
        set_nominal();
        build_stream(16'd2, 2, 1'b0);
        model_load(16'd2, 1'b0);
        send_range(0, byte_q.size() - 1);
        check_outcome("gaps");
        check_mem(2);
        gaps = 1'b0;

        // Reset after the 6th byte, then full reload
        do_reset();
        prog[0] = 32'hdead_beef;
        prog[1] = 32'h1234_5678;
        build_stream(16'd2, 2, 1'b0);
        send_range(0, 5);
        ref_mem[0] = prog[0];
        do_reset();
        set_nominal();
        build_stream(16'd2, 2, 1'b0);
        model_load(16'd2, 1'b0);
        send_range(0, byte_q.size() - 1);
        check_outcome("midrst");
        check_mem(2);

        // Read-before-write at address 0
        old0 = ref_mem[0];
        do
            new0 = $urandom;
        while (new0 == old0);
        do_reset();
        core_addr = 8'd0;
        prog[0] = new0;
        build_stream(16'd1, 1, 1'b0);
        send_range(0, 4);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = byte_q[5];
        @(negedge clk);
        s_valid = 1'b0;
        check("rbw_old", core_rdata, old0);
        @(negedge clk);
        check("rbw_new", core_rdata, new0);
        model_load(16'd1, 1'b0);
        send_range(6, 6);
        check_outcome("rbw");

        // Random frames
        gaps = 1'b1;
        for (int t = 0; t < 5; t++) begin
            do_reset();
            nw = $urandom_range(1, 12);
            corrupt = 1'($urandom_range(0, 1));
            for (int i = 0; i < nw; i++) prog[i] = $urandom;
            build_stream(16'(nw), nw, corrupt);
            model_load(16'(nw), corrupt);
            send_range(0, byte_q.size() - 1);
            check_outcome($sformatf("rand%0d", t));
            check_mem(16);
        end
        gaps = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the MIPS instruction memory. It accepts a byte stream over a valid/ready handshake, frames it as a word-count header, big-endian 32-bit instruction words and an XOR checksum, and writes the words into its internal 256x32 instruction SRAM. It holds the core in reset until a checksum-verified load completes. After that it serves the core's instruction fetch port with the same 1-cycle registered read latency as the single-port SRAM it replaces.

## Interface
- ADDR_W, 8: word-address width; memory depth is 2^ADDR_W.
- DATA_W, 32: instruction word width; must be 32.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset: synchronous, active-high. Clock clk.
- s_valid  in  1  loader byte valid.
- s_ready  out  1  loader byte ready; a byte transfers on a cycle where s_valid & s_ready are both high.
- s_data  in  8  loader byte.
- core_addr  in  ADDR_W  core fetch word address (core drives pc[9:2]).
- core_rdata  out  DATA_W  fetched word, registered, 1-cycle latency.
- core_rst  out  1  reset to the core; high until a verified load completes.
- load_done  out  1  high in RUN.
- err  out  1  high in ERR.

## Operation
- States: HDR_HI, HDR_LO, DATA, CSUM, RUN, ERR. rst forces HDR_HI.
- HDR_HI: the accepted byte becomes count[15:8]. Go to HDR_LO.
- HDR_LO: the accepted byte becomes count[7:0].
  - If {count_hi, byte} is 0 or greater than 2^ADDR_W, go to ERR.
  - Otherwise go to DATA with wr_addr=0, byte_idx=0, csum=0.
- DATA:
  - Each accepted byte does csum ^= byte and shifts into the word assembly register; the first byte is the MSB.
  - On the 4th byte (byte_idx==3), write mem[wr_addr] = {asm[23:0], s_data} at that same edge, then increment wr_addr and reset byte_idx to 0.
  - After word count-1 is written, go to CSUM.
- CSUM: if the accepted byte equals csum, go to RUN; otherwise go to ERR. The header bytes are not part of the checksum.
- RUN: s_ready=0, core_rst=0, load_done=1. Incoming bytes are ignored. Memory is read-only.
- ERR: s_ready=0, core_rst=1, err=1. The only exit is rst.
- Read port: core_rdata <= mem[core_addr] every cycle, in all states.
  - During load, writes take priority. A read of the address being written in the same cycle returns the old data (read-before-write).
- Memory contents are not cleared by rst. A reload overwrites only words 0..count-1.
- Checksum is the 8-bit XOR of all data bytes. Word-count arithmetic is 16-bit unsigned. The wr_addr counter is ADDR_W+1 bits wide so that count=256 terminates correctly without wrap.

## Timing
- s_ready = ~rst & (state in {HDR_HI, HDR_LO, DATA, CSUM}). It does not depend on s_valid.
- Throughput: 1 byte per cycle. Gaps in s_valid stall the loader with no state change.
- Reset values: s_ready=0 while rst is high and 1 on the first cycle after; core_rst=1; load_done=0; err=0; core_rdata=0.
- core_rst and load_done change on the same edge that accepts a matching checksum byte. The core sees rst low from the next cycle.
- err rises on the edge that accepts the failing header or checksum byte.
- rst asserted mid-load: next state is HDR_HI, core_rst=1, partial words are discarded. Already-written words remain in memory.
- rst asserted in RUN: core_rst reasserts on the next edge and a full reload is required.

## Structure
- Shared package mips_pkg holds:
  - the state encoding (typedef imem_ld_state_t);
  - IMEM_DEPTH=256;
  - the opcode/funct localparams already used by the core, which the bench uses to build programs.
- One sub-module: sram_sp_rbw, a single-port 256x32 registered-read RAM with read-before-write, also reusable for data memory.
- The loader FSM, counters and checksum stay in imem_loader.

## Test plan
- Nominal load: stream 00 02 | 20 01 00 05 | 00 00 00 00 | 24.
  - Required: mem[0]=0x20010005, mem[1]=0x00000000.
  - core_rst falls one cycle after the 0x24 byte; load_done=1.
  - core_addr=0 gives core_rdata=0x20010005 one cycle later.
- Bad checksum: same stream with a final byte of 0x25.
  - Required: err=1, core_rst stays 1, s_ready=0 thereafter.
- Header bounds:
  - Count 00 00: err=1 after the 2nd byte.
  - Count 01 01 (257): err=1.
  - Count 01 00 (256) with 1024 data bytes and the correct checksum: RUN, and mem[255] holds the last word.
- Backpressure/gaps: the nominal stream with s_valid toggled randomly (e.g. 1-0-0-1 pattern).
  - Required: identical memory contents and checksum result.
  - No byte accepted while s_valid=0.
- Reset mid-load: assert rst after the 6th byte for 1 cycle, then send the full nominal stream.
  - Required: correct load.
  - core_rst stays 1 throughout until the final checksum.
- Read-before-write: hold core_addr=0 during load.
  - Required: core_rdata shows the old mem[0] on the cycle after the write edge, and 0x20010005 on the following cycle.
